// File: rtl/operand_stack.sv
// LIFO operand stack of 32-bit words with an edge-triggered request handshake.
// Each accepted request takes a fixed three cycles from trigger edge to done pulse.
//
// state  | meaning
// IDLE   | waiting for a rising edge on the trigger
// ACCESS | perform the latched push/pop against memory and sp
// DONE   | operation finished; done pulse is registered out on leaving
module operand_stack #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stacktrigger_i,
  input  logic          stackpush_i,
  input  logic [31:0]   stackwrite_i,
  output logic [31:0]   stackread_o,
  output logic          stackdone_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic          trig_q;
  logic          push_q;
  logic [31:0]   wdata_q;
  logic [AW:0]   sp_q;
  logic [31:0]   rd_q;
  logic          done_q;
  logic          ovf_q;
  logic          udf_q;

  logic [31:0]   mem [DEPTH];

  logic          trig_edge;
  logic          full_w;
  logic          empty_w;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign trig_edge = stacktrigger_i & ~trig_q;
  assign full_w    = (sp_q == (AW+1)'(DEPTH));
  assign empty_w   = (sp_q == '0);
  // When sp==DEPTH the low bits wrap to 0, so sp-1 in AW bits is still the top entry.
  assign wr_addr   = sp_q[AW-1:0];
  assign rd_addr   = sp_q[AW-1:0] - AW'(1);

  // Write is gated by reset so an operation aborted in ACCESS leaves memory untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == ACCESS) && push_q && !full_w) begin
      mem[wr_addr] <= wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      trig_q  <= 1'b1;
      push_q  <= 1'b0;
      wdata_q <= '0;
      sp_q    <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      trig_q <= stacktrigger_i;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trig_edge) begin
            push_q  <= stackpush_i;
            wdata_q <= stackwrite_i;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (push_q) begin
            if (full_w) ovf_q <= 1'b1;
            else        sp_q  <= sp_q + (AW+1)'(1);
          end else if (empty_w) begin
            rd_q  <= '0;
            udf_q <= 1'b1;
          end else begin
            sp_q <= sp_q - (AW+1)'(1);
            rd_q <= mem[rd_addr];
          end
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stackread_o = rd_q;
  assign stackdone_o = done_q;
  assign count_o     = sp_q;
  assign empty_o     = empty_w;
  assign full_o      = full_w;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack (DEPTH=4): a reference stack model feeds a
// scoreboard queue that is drained and checked on every done pulse.
module tb_operand_stack;

  localparam int D  = 4;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst;
  logic          trig;
  logic          push;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          done;
  logic [AW:0]   cnt;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          udf;

  always #5 clk = ~clk;

  operand_stack #(.DEPTH(D)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stacktrigger_i (trig),
    .stackpush_i    (push),
    .stackwrite_i   (wdata),
    .stackread_o    (rdata),
    .stackdone_o    (done),
    .count_o        (cnt),
    .empty_o        (empty),
    .full_o         (full),
    .overflow_o     (ovf),
    .underflow_o    (udf)
  );

  typedef struct {
    logic [31:0] rd;
    logic [AW:0] cnt;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mstk[$];
  logic [31:0] mread;
  logic        movf;
  logic        mudf;

  int n_cmp    = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int dc0;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mstk.delete();
    sb.delete();
    mread = '0;
    movf  = 1'b0;
    mudf  = 1'b0;
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst  = 1'b1;
    trig = 1'b0;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called on a negedge; returns on the negedge where the done pulse is seen,
  // so back-to-back calls exercise the minimum three-cycle spacing.
  task automatic do_op(input bit p, input logic [31:0] d, input string tag);
    exp_t e;
    int   lat;
    if (p) begin
      if (mstk.size() < D) mstk.push_back(d);
      else                 movf = 1'b1;
    end else begin
      if (mstk.size() > 0) mread = mstk.pop_back();
      else begin
        mread = '0;
        mudf  = 1'b1;
      end
    end
    e.rd  = mread;
    e.cnt = (AW+1)'(mstk.size());
    e.ovf = movf;
    e.udf = mudf;
    sb.push_back(e);

    trig  = 1'b1;
    push  = p;
    wdata = d;
    @(negedge clk);
    trig  = 1'b0;
    wdata = '0;
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    lat = 1;
    while (done !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      chk({tag, "_timeout"}, 32'(done), 32'd1);
      void'(sb.pop_front());
    end else begin
      chk({tag, "_latency"}, 32'(lat), 32'd3);
      e = sb.pop_front();
      chk({tag, "_read"},  rdata,      e.rd);
      chk({tag, "_count"}, 32'(cnt),   32'(e.cnt));
      chk({tag, "_ovf"},   32'(ovf),   32'(e.ovf));
      chk({tag, "_udf"},   32'(udf),   32'(e.udf));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    trig  = 1'b0;
    push  = 1'b0;
    wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(cnt),   32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_read",  rdata,      32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    chk("rst_udf",   32'(udf),   32'd0);

    // pop on an empty stack straight after reset
    do_op(1'b0, 32'h0, "pop_empty");
    do_reset(2);

    // basic LIFO
    @(negedge clk);
    do_op(1'b1, 32'h11, "push11");
    do_op(1'b1, 32'h22, "push22");
    do_op(1'b1, 32'h33, "push33");
    do_op(1'b0, 32'h0,  "pop1");
    do_op(1'b0, 32'h0,  "pop2");
    do_op(1'b0, 32'h0,  "pop3");
    chk("lifo_empty", 32'(empty), 32'd1);

    // fill to DEPTH, overflow, drain
    for (int i = 1; i <= 5; i++) do_op(1'b1, 32'hA000_0000 + 32'(i), "fill");
    chk("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) do_op(1'b0, 32'h0, "drain");
    chk("drain_empty", 32'(empty), 32'd1);
    do_reset(2);

    // trigger held high for 10 cycles gives one operation
    @(negedge clk);
    dc0   = done_cnt;
    trig  = 1'b1;
    push  = 1'b1;
    wdata = 32'h55;
    repeat (10) @(negedge clk);
    trig = 1'b0;
    repeat (4) @(negedge clk);
    mstk.push_back(32'h55);
    chk("held_dones", 32'(done_cnt - dc0), 32'd1);
    chk("held_count", 32'(cnt), 32'd1);

    // edge arriving in the DONE cycle is dropped
    dc0   = done_cnt;
    trig  = 1'b1;
    push  = 1'b1;
    wdata = 32'h66;
    @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
    trig  = 1'b1;
    wdata = 32'h77;
    @(negedge clk);
    trig = 1'b0;
    chk("drop_done_seen", 32'(done), 32'd1);
    repeat (4) @(negedge clk);
    mstk.push_back(32'h66);
    chk("drop_dones", 32'(done_cnt - dc0), 32'd1);
    chk("drop_count", 32'(cnt), 32'd2);
    do_op(1'b0, 32'h0, "pop66");
    do_op(1'b0, 32'h0, "pop55");

    // reset during ACCESS of a push aborts it
    do_reset(2);
    @(negedge clk);
    dc0   = done_cnt;
    trig  = 1'b1;
    push  = 1'b1;
    wdata = 32'hAA;
    @(negedge clk);
    rst  = 1'b1;
    trig = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    chk("abort_dones", 32'(done_cnt - dc0), 32'd0);
    chk("abort_count", 32'(cnt), 32'd0);
    do_op(1'b0, 32'h0, "abort_pop");

    // trigger rising with reset and held across deassertion
    @(negedge clk);
    dc0   = done_cnt;
    rst   = 1'b1;
    trig  = 1'b1;
    push  = 1'b1;
    wdata = 32'hCC;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("held_rst_dones", 32'(done_cnt - dc0), 32'd0);
    chk("held_rst_count", 32'(cnt), 32'd0);
    trig = 1'b0;
    @(negedge clk);
    do_op(1'b1, 32'hCC, "post_rst_push");
    do_op(1'b0, 32'h0,  "post_rst_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 Parameter: DEPTH, 256, number of 32-bit entries; power of two, >= 4.
REQ-002 Parameter: AW, $clog2(DEPTH), entry address width, derived.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stacktrigger  input  1  request line; an operation starts on its rising edge only.
REQ-006 stackpush  input  1  1 = push, 0 = pop; sampled with the trigger edge.
REQ-007 stackwrite  input  32  push data; sampled with the trigger edge.
REQ-008 stackread  output  32  popped value; valid while stackdone=1, held until next pop completes.
REQ-009 stackdone  output  1  one-cycle completion pulse per accepted operation.
REQ-010 count  output  AW+1  current number of stored entries, 0..DEPTH.
REQ-011 empty  output  1  count==0.
REQ-012 full  output  1  count==DEPTH.
REQ-013 overflow  output  1  sticky; push attempted while full.
REQ-014 underflow  output  1  sticky; pop attempted while empty.

Function
REQ-015 Block SHALL register stacktrigger into trig_q each cycle; edge = stacktrigger & ~trig_q.
REQ-016 States SHALL be IDLE, ACCESS, DONE; unused encodings SHALL return to IDLE.
REQ-017 IDLE: on edge, latch stackpush and stackwrite, go to ACCESS; otherwise stay IDLE.
REQ-018 Edges seen in ACCESS or DONE SHALL be ignored (no queueing, no flag change).
REQ-019 ACCESS push, not full: mem[sp] <= data, sp <= sp+1.
REQ-020 ACCESS pop, not empty: sp <= sp-1, read mem[sp-1] into stackread register (synchronous-read memory permitted).
REQ-021 ACCESS push while full: write dropped, sp unchanged, overflow <= 1.
REQ-022 ACCESS pop while empty: sp unchanged, stackread <= 0, underflow <= 1.
REQ-023 ACCESS SHALL always go to DONE; DONE SHALL drive stackdone=1 for exactly that cycle and return to IDLE.
REQ-024 Latency: edge sampled at clock edge N, stackdone high in the cycle following clock edge N+2; fixed, identical for push, pop and error cases.
REQ-025 stackdone SHALL pulse also for rejected (overflow/underflow) operations.
REQ-026 A push SHALL NOT alter stackread.
REQ-027 count, empty, full SHALL reflect sp updated at the ACCESS→DONE edge.
REQ-028 Minimum spacing between accepted operations: 3 cycles; a new edge in the DONE cycle is dropped, an edge in the cycle after DONE is accepted.
REQ-029 Stack SHALL be LIFO: n pushes of v1..vn then n pops SHALL return vn..v1.
REQ-030 sp SHALL never wrap; it stays within 0..DEPTH.

Reset
REQ-031 rst SHALL set state=IDLE, sp=0, stackread=0, stackdone=0, overflow=0, underflow=0; count=0, empty=1, full=0.
REQ-032 rst SHALL set trig_q=1 so a trigger held high through reset is not an edge.
REQ-033 rst mid-operation SHALL abort it: no stackdone, no memory-visible effect; memory contents need not be cleared.
REQ-034 rst SHALL override any simultaneous trigger edge.

Verification
REQ-035 Push 0x11, 0x22, 0x33 then pop x3 -> stackread 0x33, 0x22, 0x11 on each stackdone; count 3→0; empty=1 at end.
REQ-036 Pop after reset -> stackdone pulses 3 cycles after edge, stackread=0, underflow=1, count=0.
REQ-037 DEPTH=4: push 5 values -> 5th done pulse, overflow=1, count=4; 4 pops return 4th..1st values.
REQ-038 Trigger held high 10 cycles -> exactly one operation and one stackdone; second edge during DONE ignored, edge one cycle later accepted.
REQ-039 rst asserted in ACCESS of push 0xAA -> no stackdone, count=0; later pop -> underflow=1.
REQ-040 Trigger held high across rst deassertion -> no operation until trigger drops and rises again.
